uart_receiver: RTL



---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_receiver_if.sv | 50 +++++
 rtl/uart_tick_gen.sv | 53 +++++
 rtl/uart_receiver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path:
//   - uart_state_t    : receiver FSM states
//   - IDLE_LEVEL      : level of the serial line when idle (mark)
//   - tick_div()      : oversampling tick divider, floor(FREQ_SYS/(BAUD*OS))
//   - tick_cnt_width(): width of the tick divider counter
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_state_t;

    function automatic int tick_div(input int freq_sys, input int baud_rate, input int oversample);
        return freq_sys / (baud_rate * oversample);
    endfunction

    // A divider of 1 still needs a 1-bit counter
    function automatic int tick_cnt_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_receiver_if
// Serial input and character handshake of the UART receiver.
//   rxIn      : serial line, asynchronous, idles high
//   rxAck     : consumer acknowledge, clears rxValid/overrun
//   rxData    : last good character
//   rxValid   : unacknowledged character held
//   frameErr  : one-cycle pulse, stop bit sampled low
//   overrun   : sticky, good character completed while rxValid was high
//   parityErr : one-cycle pulse, even parity check failed
//               (only when UART_RX_PARITY_EN is defined)
// Modports: slave = receiver side, master = line driver / consumer side.
// -----------------------------------------------------------------------------
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 rxIn;
    logic                 rxAck;
    logic [DATA_BITS-1:0] rxData;
    logic                 rxValid;
    logic                 frameErr;
    logic                 overrun;
`ifdef UART_RX_PARITY_EN
    logic                 parityErr;
`endif

    modport slave (
        input  rxIn,
        input  rxAck,
        output rxData,
        output rxValid,
        output frameErr,
`ifdef UART_RX_PARITY_EN
        output parityErr,
`endif
        output overrun
    );

    modport master (
        output rxIn,
        output rxAck,
        input  rxData,
        input  rxValid,
        input  frameErr,
`ifdef UART_RX_PARITY_EN
        input  parityErr,
`endif
        input  overrun
    );
endinterface

// File: rtl/uart_tick_gen.sv
// -----------------------------------------------------------------------------
// uart_tick_gen
// Free-running oversampling tick generator. The counter runs 0..TICK_DIV-1
// and tick is high for the single cycle in which the counter is TICK_DIV-1.
// The counter is never re-phased to the line.
// Ports:
//   clkSys : system clock
//   rst    : asynchronous active-high reset
//   tick   : one-cycle oversampling tick
// -----------------------------------------------------------------------------
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int FREQ_SYS   = 125000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clkSys,
    input  logic rst,
    output logic tick
);
    localparam int TICK_DIV = tick_div(FREQ_SYS, BAUD_RATE, OVERSAMPLE);
    localparam int CNT_W    = tick_cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             tick_r;

    // Next divider count, wrapping after the last position
    always_comb begin
        if (cnt_r == CNT_LAST) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Divider register; tick_r is registered so it is high while cnt_r == CNT_LAST
    always_ff @(posedge clkSys or posedge rst) begin
        if (rst) begin
            cnt_r  <= CNT_ZERO;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == CNT_LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// UART receive path: 2-flop synchroniser, oversampled deframing of
// start / DATA_BITS LSB-first data / stop, valid/ack character handshake,
// framing error pulse and sticky overrun flag.
// Optional build macro UART_RX_PARITY_EN adds an even parity bit between data
// and stop, checked into a one-cycle parityErr pulse beside the rxValid rise.
// Ports:
//   clkSys : system clock
//   rst    : asynchronous active-high reset
//   bus    : uart_receiver_if.slave (rxIn, rxAck, rxData, rxValid,
//            frameErr, overrun[, parityErr])
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BAUD_RATE  = 9600,
    parameter int FREQ_SYS   = 125000000,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic           clkSys,
    input  logic           rst,
    uart_receiver_if.slave bus
);
    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [SC_W-1:0] SC_ZERO = {SC_W{1'b0}};
    localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_ZERO = {BC_W{1'b0}};
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    logic                 sync_r;
    logic                 rx_s_r;
    logic                 tick_s;
    uart_state_t          state_r, state_nxt_s;
    logic [SC_W-1:0]      sample_cnt_r, sample_cnt_nxt_s;
    logic [BC_W-1:0]      bit_cnt_r, bit_cnt_nxt_s;
    logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
    logic                 good_s;
    logic                 bad_s;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 frame_err_r;
    logic                 overrun_r;
`ifdef UART_RX_PARITY_EN
    logic                 parity_r, parity_nxt_s;
    logic                 parity_err_r;

    // Even parity holds when data plus parity bit has an even number of ones
    function automatic logic parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return ~(^{d, p});
    endfunction
`endif

    uart_tick_gen #(
        .FREQ_SYS   (FREQ_SYS),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_gen (
        .clkSys (clkSys),
        .rst    (rst),
        .tick   (tick_s)
    );

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clkSys or posedge rst) begin
        if (rst) begin
            sync_r <= IDLE_LEVEL;
            rx_s_r <= IDLE_LEVEL;
        end else begin
            sync_r <= bus.rxIn;
            rx_s_r <= sync_r;
        end
    end

    // Deframing FSM state, sample/bit counters and shift register
    always_ff @(posedge clkSys or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            sample_cnt_r <= SC_ZERO;
            bit_cnt_r    <= BC_ZERO;
            shift_r      <= {DATA_BITS{1'b0}};
`ifdef UART_RX_PARITY_EN
            parity_r     <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt_s;
            sample_cnt_r <= sample_cnt_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            shift_r      <= shift_nxt_s;
`ifdef UART_RX_PARITY_EN
            parity_r     <= parity_nxt_s;
`endif
        end
    end

    // Next-state logic; good_s/bad_s strobe on the stop-bit sample tick
    always_comb begin
        state_nxt_s      = state_r;
        sample_cnt_nxt_s = sample_cnt_r;
        bit_cnt_nxt_s    = bit_cnt_r;
        shift_nxt_s      = shift_r;
        good_s           = 1'b0;
        bad_s            = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_nxt_s     = parity_r;
`endif
        case (state_r)
            IDLE: begin
                if (rx_s_r != IDLE_LEVEL) begin
                    state_nxt_s      = START;
                    sample_cnt_nxt_s = SC_ZERO;
                end else begin
                    state_nxt_s      = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    if (sample_cnt_r == SC_HALF) begin
                        // Mid start bit: a high line here was only a glitch
                        sample_cnt_nxt_s = SC_ZERO;
                        bit_cnt_nxt_s    = BC_ZERO;
                        if (rx_s_r != IDLE_LEVEL) begin
                            state_nxt_s = DATA;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        sample_cnt_nxt_s = sample_cnt_r + SC_W'(1);
                    end
                end else begin
                    sample_cnt_nxt_s = sample_cnt_r;
                end
            end
            DATA: begin
                if (tick_s) begin
                    if (sample_cnt_r == SC_LAST) begin
                        // LSB arrives first, so shift in from the top
                        shift_nxt_s      = {rx_s_r, shift_r[DATA_BITS-1:1]};
                        sample_cnt_nxt_s = SC_ZERO;
                        if (bit_cnt_r == BC_LAST) begin
                            bit_cnt_nxt_s = BC_ZERO;
`ifdef UART_RX_PARITY_EN
                            state_nxt_s   = PARITY;
`else
                            state_nxt_s   = STOP;
`endif
                        end else begin
                            bit_cnt_nxt_s = bit_cnt_r + BC_W'(1);
                        end
                    end else begin
                        sample_cnt_nxt_s = sample_cnt_r + SC_W'(1);
                    end
                end else begin
                    sample_cnt_nxt_s = sample_cnt_r;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_s) begin
                    if (sample_cnt_r == SC_LAST) begin
                        parity_nxt_s     = rx_s_r;
                        sample_cnt_nxt_s = SC_ZERO;
                        state_nxt_s      = STOP;
                    end else begin
                        sample_cnt_nxt_s = sample_cnt_r + SC_W'(1);
                    end
                end else begin
                    sample_cnt_nxt_s = sample_cnt_r;
                end
            end
`endif
            STOP: begin
                if (tick_s) begin
                    if (sample_cnt_r == SC_LAST) begin
                        sample_cnt_nxt_s = SC_ZERO;
                        if (rx_s_r == IDLE_LEVEL) begin
                            good_s      = 1'b1;
                            state_nxt_s = IDLE;
                        end else begin
                            // Held-low line or break must not retrigger reception
                            bad_s       = 1'b1;
                            state_nxt_s = WAIT_IDLE;
                        end
                    end else begin
                        sample_cnt_nxt_s = sample_cnt_r + SC_W'(1);
                    end
                end else begin
                    sample_cnt_nxt_s = sample_cnt_r;
                end
            end
            WAIT_IDLE: begin
                if (rx_s_r == IDLE_LEVEL) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Character handshake and error flags; a completing byte beats a same-cycle ack
    always_ff @(posedge clkSys or posedge rst) begin
        if (rst) begin
            data_r       <= {DATA_BITS{1'b0}};
            valid_r      <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            frame_err_r  <= bad_s;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= good_s & ~parity_ok(shift_r, parity_r);
`endif
            if (good_s) begin
                data_r    <= shift_r;
                valid_r   <= 1'b1;
                overrun_r <= valid_r & ~bus.rxAck;
            end else if (bus.rxAck) begin
                valid_r   <= 1'b0;
                overrun_r <= 1'b0;
            end else begin
                valid_r   <= valid_r;
                overrun_r <= overrun_r;
            end
        end
    end

    assign bus.rxData   = data_r;
    assign bus.rxValid  = valid_r;
    assign bus.frameErr = frame_err_r;
    assign bus.overrun  = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parityErr = parity_err_r;
`endif

endmodule
